mtm_write_sched: RTL and testbench
==================================

MTM_WRITE_SCHED -- requirements
Module: mtm_write_sched

Interface
REQ-001 Parameter WIDTH, default 4, width of the written value.
REQ-002 Parameter CNTW, default 8, width of the delay fields and the delay counter.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  run enable for periodic scheduling.
REQ-006 mtm_sel  input  2  delay select: 00 min, 01 typ, 10 max, 11 typ.
REQ-007 dly_min  input  CNTW  minimum delay, in cycles.
REQ-008 dly_typ  input  CNTW  typical delay, in cycles.
REQ-009 dly_max  input  CNTW  maximum delay, in cycles.
REQ-010 req  input  2  write requests; bit i belongs to requester i.
REQ-011 data0  input  WIDTH  value offered by requester 0.
REQ-012 data1  input  WIDTH  value offered by requester 1.
REQ-013 value  output  WIDTH  scheduled register contents.
REQ-014 value_valid  output  1  high once value has been written at least once.
REQ-015 wr_pulse  output  1  one-cycle strobe marking a value update.
REQ-016 grant  output  2  one-hot winner of the write; valid while wr_pulse is high, else 00.
REQ-017 busy  output  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, COUNT and WRITE.
REQ-019 In IDLE with en=1, the block SHALL latch D = the delay picked by mtm_sel, load cnt=D-1 and go to COUNT; a selected delay of 0 SHALL be treated as D=1.
REQ-020 In COUNT, the block SHALL go to WRITE on an edge where cnt==0, and SHALL otherwise decrement cnt, so COUNT lasts exactly D cycles.
REQ-021 WRITE SHALL last one cycle; on its closing edge value, wr_pulse, grant and value_valid SHALL update as REQ-023..REQ-026 require.
REQ-022 When leaving WRITE, the block SHALL re-sample mtm_sel and the delays and reload COUNT if en=1, else go to IDLE; with en held, writes SHALL repeat every D+1 cycles.
REQ-023 Arbitration SHALL be round-robin:
- a single request always wins;
- with both requesting, the requester not granted last wins;
- after reset, requester 0 has priority.
REQ-024 On a granted write: value SHALL take the winner's data, grant SHALL be the winner one-hot, wr_pulse SHALL be 1 and value_valid SHALL be 1.
REQ-025 If req=00 at WRITE, no write SHALL occur: wr_pulse=0, grant=00, value held, round-robin pointer unchanged.
REQ-026 wr_pulse and grant SHALL be high for exactly one cycle per write and 0 in every other cycle.
REQ-027 en=0 sampled in COUNT SHALL abort to IDLE on that edge with no write; value and value_valid SHALL be held.
REQ-028 Changes to mtm_sel or the delay inputs during COUNT SHALL be ignored until the next reload.
REQ-029 All outputs SHALL be registered; busy SHALL be derived from registered state only.
REQ-030 Latency SHALL be as follows: with en sampled high in IDLE at edge e0, wr_pulse SHALL be high in the cycle following edge e0+D+1.

Reset
REQ-031 While reset=1, the block SHALL immediately force state=IDLE, cnt=0, value=0, value_valid=0, wr_pulse=0, grant=00, busy=0 and round-robin priority to requester 0, independent of clk.
REQ-032 Reset asserted mid-COUNT or mid-WRITE SHALL drop any pending write; after deassertion the block SHALL resume from IDLE on the first rising edge.

Verification
REQ-033 Scenario: reset pulse with no clock edge -> value=0, value_valid=0, wr_pulse=0, grant=00, busy=0 immediately.
REQ-034 Scenario: mtm_sel=01, dly_typ=10, req=01, data0=4'h5, en held -> first wr_pulse 11 edges after en is sampled, value=4'h5, value_valid=1, grant=01; repeats every 11 cycles.
REQ-035 Scenario: mtm_sel=00 with dly_min=3, then mtm_sel=10 with dly_max=15 -> first-write latencies of 4 and 16 edges respectively; dly_min=0 -> latency 2.
REQ-036 Scenario: req=11, data0=4'h5, data1=4'hA, en held -> grant sequence 01,10,01,10 and value sequence 5,A,5,A.
REQ-037 Scenario: en dropped while cnt=4 -> IDLE on the next edge, busy=0, no wr_pulse, value unchanged; req=00 at WRITE -> no wr_pulse and value held.
REQ-038 Scenario: reset asserted asynchronously mid-COUNT after one write of 4'h5 -> value=0 and value_valid=0 before the next edge; no wr_pulse follows.

Source files
------------

// File: rtl/mtm_write_sched_if.sv
// mtm_write_sched_if
//   Bundles the scheduling controls, requester inputs and status outputs of
//   mtm_write_sched. The master side (the environment) drives the enable,
//   delay selection, delay values, requests and data. The slave side (the
//   scheduler) drives the scheduled value and its status strobes.
//
//   Signals:
//     en          run enable for periodic scheduling
//     mtm_sel     delay select: 00 min, 01 typ, 10 max, 11 typ
//     dly_min/typ/max  delay candidates, in cycles (CNTW bits)
//     req         write requests, bit i = requester i
//     data0/data1 values offered by requesters 0 and 1 (WIDTH bits)
//     value       scheduled register contents
//     value_valid high once value has been written at least once
//     wr_pulse    one-cycle strobe per value update
//     grant       one-hot winner, non-zero only with wr_pulse
//     busy        high whenever the scheduler is not idle
interface mtm_write_sched_if #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
);
    logic             en;
    logic [1:0]       mtm_sel;
    logic [CNTW-1:0]  dly_min;
    logic [CNTW-1:0]  dly_typ;
    logic [CNTW-1:0]  dly_max;
    logic [1:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] value;
    logic             value_valid;
    logic             wr_pulse;
    logic [1:0]       grant;
    logic             busy;

    modport master (
        output en, mtm_sel, dly_min, dly_typ, dly_max, req, data0, data1,
        input  value, value_valid, wr_pulse, grant, busy
    );

    modport slave (
        input  en, mtm_sel, dly_min, dly_typ, dly_max, req, data0, data1,
        output value, value_valid, wr_pulse, grant, busy
    );
endinterface

// File: rtl/mtm_write_sched.sv
// mtm_write_sched
//   Periodic, delay-selectable write scheduler with a two-requester
//   round-robin arbiter. While enabled, it waits D cycles (D picked from
//   min/typ/max by mtm_sel, 0 treated as 1), then spends one WRITE cycle,
//   at whose closing edge the winning requester's data is written into
//   value. With en held, writes repeat every D+1 cycles.
//
//   Ports:
//     clk    sole clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    mtm_write_sched_if.slave (see interface header for signals)
module mtm_write_sched #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    mtm_write_sched_if.slave      bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNTW-1:0]  cnt_reg, cnt_next;
    logic [WIDTH-1:0] value_reg, value_next;
    logic             valid_reg, valid_next;
    logic             wr_pulse_reg, wr_pulse_next;
    logic [1:0]       grant_reg, grant_next;
    // Index of the requester granted last; resets to 1 so requester 0
    // wins the first contested write.
    logic             rr_last_reg, rr_last_next;

    logic [CNTW-1:0]  sel_dly;
    logic [CNTW-1:0]  load_cnt;
    logic             any_req;
    logic             win_idx;
    logic [1:0]       grant_onehot;
    logic [WIDTH-1:0] win_data;

    // Delay selection; code 11 aliases typ.
    always_comb begin
        case (bus.mtm_sel)
            2'b00:   sel_dly = bus.dly_min;
            2'b10:   sel_dly = bus.dly_max;
            default: sel_dly = bus.dly_typ;
        endcase
    end

    // COUNT lasts cnt+1 cycles, so load D-1; a zero delay behaves as D=1.
    assign load_cnt = (sel_dly == '0) ? '0 : sel_dly - 1'b1;

    // Round-robin: a lone request wins outright, a tie goes to the
    // requester that was not granted last.
    assign any_req  = |bus.req;
    assign win_idx  = (bus.req == 2'b11) ? ~rr_last_reg : bus.req[1];
    assign win_data = win_idx ? bus.data1 : bus.data0;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant_onehot[gi] = any_req && (win_idx == 1'(gi));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        value_next    = value_reg;
        valid_next    = valid_reg;
        wr_pulse_next = 1'b0;
        grant_next    = 2'b00;
        rr_last_next  = rr_last_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.en) begin
                    cnt_next   = load_cnt;
                    state_next = S_COUNT;
                end
            end
            S_COUNT: begin
                // Dropping en aborts the pending write, even on the last
                // count cycle.
                if (!bus.en) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = S_WRITE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            S_WRITE: begin
                if (any_req) begin
                    value_next    = win_data;
                    valid_next    = 1'b1;
                    wr_pulse_next = 1'b1;
                    grant_next    = grant_onehot;
                    rr_last_next  = win_idx;
                end
                // Delay inputs are re-sampled here, so changes made
                // during COUNT take effect only from this reload.
                if (bus.en) begin
                    cnt_next   = load_cnt;
                    state_next = S_COUNT;
                end else begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            value_reg    <= '0;
            valid_reg    <= 1'b0;
            wr_pulse_reg <= 1'b0;
            grant_reg    <= 2'b00;
            rr_last_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            value_reg    <= value_next;
            valid_reg    <= valid_next;
            wr_pulse_reg <= wr_pulse_next;
            grant_reg    <= grant_next;
            rr_last_reg  <= rr_last_next;
        end
    end

    assign bus.value       = value_reg;
    assign bus.value_valid = valid_reg;
    assign bus.wr_pulse    = wr_pulse_reg;
    assign bus.grant       = grant_reg;
    assign bus.busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mtm_write_sched.sv
// tb_mtm_write_sched
//   Self-checking bench for mtm_write_sched: a vector table for first-write
//   latency per delay selection, a scoreboard of expected writes checked on
//   every wr_pulse, and hand-written sequences for round-robin, abort,
//   empty-request and asynchronous reset behaviour.
module tb_mtm_write_sched;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] dmin;
        logic [7:0] dtyp;
        logic [7:0] dmax;
        logic [1:0] req;
        logic [3:0] d0;
        logic [3:0] d1;
        int         lat;
        logic [3:0] val;
        logic [1:0] gnt;
    } vec_t;

    typedef struct {
        logic [1:0] gnt;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic reset;

    mtm_write_sched_if #(.WIDTH(4), .CNTW(8)) bus ();

    mtm_write_sched #(.WIDTH(4), .CNTW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_total   = 0;
    int   n_pass    = 0;
    int   pulse_cnt = 0;
    bit   mon_on    = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_total++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req_v);
    endtask

    // Scoreboard monitor: every write must match the oldest expectation,
    // and grant must be 00 in every non-write cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.wr_pulse === 1'b1) begin
                exp_t e;
                pulse_cnt++;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_write: got grant=%b value=%h, required no write",
                             bus.grant, bus.value);
                end else begin
                    e = sb.pop_front();
                    $display("write: grant=%b value=%h (expected %b/%h)", bus.grant, bus.value, e.gnt, e.val);
                    check("sb_grant", 32'(bus.grant), 32'(e.gnt));
                    check("sb_value", 32'(bus.value), 32'(e.val));
                end
            end else begin
                check("quiet_grant", 32'(bus.grant), 32'd0);
            end
        end
    end

    // Wait for the next wr_pulse, bounded; returns negedges waited.
    task automatic wait_pulse(input int budget, output int waited);
        waited = budget + 1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (bus.wr_pulse === 1'b1) begin
                waited = k;
                break;
            end
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int w;
        bus.mtm_sel = v.sel;
        bus.dly_min = v.dmin;
        bus.dly_typ = v.dtyp;
        bus.dly_max = v.dmax;
        bus.req     = v.req;
        bus.data0   = v.d0;
        bus.data1   = v.d1;
        sb.push_back('{gnt: v.gnt, val: v.val});
        bus.en = 1'b1;
        wait_pulse(40, w);
        // en was applied before edge e0; the w-th edge after that is e0+w-1.
        $display("vec %0d: sel=%b latency=%0d (expected %0d)", idx, v.sel, w - 1, v.lat);
        check("latency", 32'(w - 1), 32'(v.lat));
        check("vec_value", 32'(bus.value), 32'(v.val));
        check("vec_valid", 32'(bus.value_valid), 32'd1);
        bus.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("vec_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[5];

    initial begin
        int w;
        int p0;

        vecs[0] = '{sel: 2'b01, dmin: 8'd3, dtyp: 8'd10, dmax: 8'd15, req: 2'b01, d0: 4'h5, d1: 4'hA, lat: 11, val: 4'h5, gnt: 2'b01};
        vecs[1] = '{sel: 2'b00, dmin: 8'd3, dtyp: 8'd10, dmax: 8'd15, req: 2'b01, d0: 4'h6, d1: 4'hA, lat: 4,  val: 4'h6, gnt: 2'b01};
        vecs[2] = '{sel: 2'b10, dmin: 8'd3, dtyp: 8'd10, dmax: 8'd15, req: 2'b10, d0: 4'h6, d1: 4'h9, lat: 16, val: 4'h9, gnt: 2'b10};
        vecs[3] = '{sel: 2'b00, dmin: 8'd0, dtyp: 8'd10, dmax: 8'd15, req: 2'b01, d0: 4'h3, d1: 4'h9, lat: 2,  val: 4'h3, gnt: 2'b01};
        vecs[4] = '{sel: 2'b11, dmin: 8'd0, dtyp: 8'd2,  dmax: 8'd15, req: 2'b10, d0: 4'h3, d1: 4'hA, lat: 3,  val: 4'hA, gnt: 2'b10};

        reset       = 1'b0;
        bus.en      = 1'b0;
        bus.mtm_sel = 2'b00;
        bus.dly_min = '0;
        bus.dly_typ = '0;
        bus.dly_max = '0;
        bus.req     = 2'b00;
        bus.data0   = '0;
        bus.data1   = '0;

        // Asynchronous reset, observed before any rising edge.
        #2 reset = 1'b1;
        #1;
        $display("reset: value=%h valid=%b pulse=%b grant=%b busy=%b",
                 bus.value, bus.value_valid, bus.wr_pulse, bus.grant, bus.busy);
        check("rst_value", 32'(bus.value), 32'd0);
        check("rst_valid", 32'(bus.value_valid), 32'd0);
        check("rst_pulse", 32'(bus.wr_pulse), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        mon_on = 1;

        // Table of first-write latencies.
        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Round-robin with both requesting, en held: 01,10,01,10 every D+1.
        do_reset();
        bus.req     = 2'b11;
        bus.data0   = 4'h5;
        bus.data1   = 4'hA;
        bus.mtm_sel = 2'b01;
        bus.dly_typ = 8'd2;
        for (int i = 0; i < 4; i++)
            sb.push_back('{gnt: (i % 2 == 0) ? 2'b01 : 2'b10, val: (i % 2 == 0) ? 4'h5 : 4'hA});
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(20, w);
            // First gap is the latency from e0 (w-1); later gaps are edge-to-edge.
            $display("rr write %0d: interval=%0d (expected 3)", i, (i == 0) ? w - 1 : w);
            check("rr_interval", 32'((i == 0) ? w - 1 : w), 32'd3);
        end
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_sb_empty", 32'(sb.size()), 32'd0);

        // Abort with cnt=4: IDLE on next edge, no write, value held (A).
        bus.req     = 2'b01;
        bus.data0   = 4'h5;
        bus.dly_typ = 8'd10;
        p0 = pulse_cnt;
        bus.en = 1'b1;
        repeat (6) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        $display("abort: busy=%b value=%h", bus.busy, bus.value);
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (15) @(negedge clk);
        check("abort_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("abort_value", 32'(bus.value), 32'hA);
        check("abort_valid", 32'(bus.value_valid), 32'd1);

        // req=00 at WRITE: cycles through WRITE without updating anything.
        bus.req     = 2'b00;
        bus.mtm_sel = 2'b00;
        bus.dly_min = 8'd1;
        p0 = pulse_cnt;
        bus.en = 1'b1;
        repeat (12) @(negedge clk);
        $display("no-req: busy=%b pulses=%0d value=%h", bus.busy, pulse_cnt - p0, bus.value);
        check("noreq_busy", 32'(bus.busy), 32'd1);
        check("noreq_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("noreq_value", 32'(bus.value), 32'hA);
        bus.en = 1'b0;
        repeat (2) @(negedge clk);

        // Reset mid-COUNT after one write of 5.
        do_reset();
        bus.req     = 2'b01;
        bus.data0   = 4'h5;
        bus.mtm_sel = 2'b01;
        bus.dly_typ = 8'd6;
        sb.push_back('{gnt: 2'b01, val: 4'h5});
        bus.en = 1'b1;
        wait_pulse(30, w);
        check("mid_latency", 32'(w - 1), 32'd7);
        check("mid_value", 32'(bus.value), 32'h5);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        $display("mid-count reset: value=%h valid=%b busy=%b", bus.value, bus.value_valid, bus.busy);
        check("mid_rst_value", 32'(bus.value), 32'd0);
        check("mid_rst_valid", 32'(bus.value_valid), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_pulse", 32'(bus.wr_pulse), 32'd0);
        bus.en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        p0 = pulse_cnt;
        repeat (15) @(negedge clk);
        check("mid_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        check("mid_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
